fifo1_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO (fifo1), running entirely in the rclk domain.
//  - Drains bytes from the FIFO and packs PACK of them into one wide word (first byte

---
 rtl/fifo1_rd_packer_pkg.sv | 18 +
 rtl/fifo1_rd_packer_if.sv | 27 ++
 rtl/fifo1_rd_packer_out_reg.sv | 35 +++
 rtl/fifo1_rd_packer.sv | 145 ++++++++++++++
 tb/tb_fifo1_rd_packer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo1_rd_packer_pkg.sv
// Shared definitions for the fifo1 read-side byte packer: FSM encodings,
// default widths and counter sizing.
package fifo1_rd_packer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PACK_DEF       = 4;
   localparam int TIMEOUT_DEF    = 16;

   // A disabled timeout still needs a legal one-bit idle counter.
   function automatic int idle_width(input int timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage

// File: rtl/fifo1_rd_packer_if.sv
// Read-port (FIFO head + pop) and packed-word valid/ready bundle of the packer.
interface fifo1_rd_packer_if
   import fifo1_rd_packer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PACK       = PACK_DEF
) ();

   logic                       rempty;
   logic [DATA_WIDTH-1:0]      rdata;
   logic                       rinc;
   logic                       out_valid;
   logic [PACK*DATA_WIDTH-1:0] out_data;
   logic [PACK-1:0]            out_keep;
   logic                       out_ready;

   modport master (
      input  rempty, rdata, out_ready,
      output rinc, out_valid, out_data, out_keep
   );

   modport slave (
      output rempty, rdata, out_ready,
      input  rinc, out_valid, out_data, out_keep
   );

endinterface

// File: rtl/fifo1_rd_packer_out_reg.sv
// Valid/ready holding register for packed words; contents stay frozen while
// a word is presented but not yet accepted.
module pack_out_reg #(
   parameter int W  = 32,
   parameter int KW = 4
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          load,
   input  logic [W-1:0]  load_data,
   input  logic [KW-1:0] load_keep,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic [KW-1:0] out_keep,
   output logic          out_free
);

   assign out_free = !out_valid || out_ready;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_keep  <= load_keep;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo1_rd_packer.sv
// Drains fifo1 bytes in the rclk domain, packs PACK of them per word (first
// byte in lane 0) and flushes partially filled words after TIMEOUT idle cycles.
module fifo1_rd_packer
   import fifo1_rd_packer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PACK       = PACK_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic              rclk,
   input  logic              rrst_n,
   fifo1_rd_packer_if.master bus
);

   localparam int W      = PACK * DATA_WIDTH;
   localparam int CNT_W  = $clog2(PACK);
   localparam int IDLE_W = idle_width(TIMEOUT);

   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PACK - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_SAT   = '1;

   logic [1:0]        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [IDLE_W-1:0] idle, idle_nxt, idle_inc;
   logic [W-1:0]      acc, acc_nxt, acc_pop, word_data, load_data;
   logic [PACK-1:0]   keep, keep_nxt, keep_pop, word_keep, load_keep;
   logic              pop, out_free, load, word_done, timeout_hit;

   assign pop      = rrst_n && !bus.rempty && (state != ST_HOLD);
   assign bus.rinc = pop;

   assign idle_inc    = (idle == IDLE_SAT) ? idle : idle + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (idle_inc == IDLE_LIMIT);

   always_comb begin
      acc_pop                                 = acc;
      acc_pop[cnt*DATA_WIDTH +: DATA_WIDTH]   = bus.rdata;
      keep_pop                                = keep;
      keep_pop[cnt]                           = 1'b1;
   end

   // A completed word (full, flushed, or parked in HOLD) leaves through word_*;
   // it loads the output register if free, otherwise waits in HOLD.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idle_nxt  = idle;
      acc_nxt   = acc;
      keep_nxt  = keep;
      word_done = 1'b0;
      word_data = acc;
      word_keep = keep;
      load      = 1'b0;
      load_data = acc;
      load_keep = keep;

      case (state)
         ST_IDLE: begin
            idle_nxt = '0;
            if (pop) begin
               acc_nxt   = acc_pop;
               keep_nxt  = keep_pop;
               cnt_nxt   = CNT_W'(1);
               state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (pop) begin
               idle_nxt = '0;
               if (cnt == CNT_LAST) begin
                  word_done = 1'b1;
                  word_data = acc_pop;
                  word_keep = keep_pop;
               end else begin
                  acc_nxt  = acc_pop;
                  keep_nxt = keep_pop;
                  cnt_nxt  = cnt + 1'b1;
               end
            end else begin
               idle_nxt = idle_inc;
               if (timeout_hit) begin
                  word_done = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            word_done = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (word_done) begin
         idle_nxt = '0;
         if (out_free) begin
            load      = 1'b1;
            load_data = word_data;
            load_keep = word_keep;
            acc_nxt   = '0;
            keep_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end else begin
            acc_nxt   = word_data;
            keep_nxt  = word_keep;
            state_nxt = ST_HOLD;
         end
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idle  <= '0;
         acc   <= '0;
         keep  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idle  <= idle_nxt;
         acc   <= acc_nxt;
         keep  <= keep_nxt;
      end
   end

   pack_out_reg #(
      .W  (W),
      .KW (PACK)
   ) u_out_reg (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .load      (load),
      .load_data (load_data),
      .load_keep (load_keep),
      .out_ready (bus.out_ready),
      .out_valid (bus.out_valid),
      .out_data  (bus.out_data),
      .out_keep  (bus.out_keep),
      .out_free  (out_free)
   );

endmodule

// File: tb/tb_fifo1_rd_packer.sv
// Directed bench for fifo1_rd_packer: behavioural fall-through FIFO written
// from wclk, words collected at the opposite rclk edge.
module tb_fifo1_rd_packer;
   import fifo1_rd_packer_pkg::*;

   logic rclk = 1'b0;
   logic wclk = 1'b0;
   logic rrst_n;

   always #35 rclk = ~rclk;
   always #50 wclk = ~wclk;

   fifo1_rd_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus ();
   fifo1_rd_packer_if #(.DATA_WIDTH(8), .PACK(4)) bus0 ();

   fifo1_rd_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(16)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus)
   );

   fifo1_rd_packer #(.DATA_WIDTH(8), .PACK(4), .TIMEOUT(0)) dut0 (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus0)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int pops         = 0;
   int empty_pops   = 0;
   int last_pop_cyc = 0;
   int rise_cyc     = 0;
   bit prev_valid   = 1'b0;

   logic [7:0]  fq[$];
   logic [31:0] got_data[$];
   logic [3:0]  got_keep[$];
   int          got_cyc[$];

   // FIFO model: writes become visible one rclk after being pushed.
   always @(posedge rclk) begin
      cyc++;
      if (bus.rinc) begin
         pops++;
         last_pop_cyc = cyc;
         if (bus.rempty) empty_pops++;
         else void'(fq.pop_front());
      end
      bus.rempty <= (fq.size() == 0);
      bus.rdata  <= (fq.size() != 0) ? fq[0] : 8'h00;
   end

   always @(negedge rclk) begin
      if (bus.out_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
         got_data.push_back(bus.out_data);
         got_keep.push_back(bus.out_keep);
         got_cyc.push_back(cyc);
      end
   end

   task automatic write_byte(input logic [7:0] b);
      @(posedge wclk);
      fq.push_back(b);
   endtask

   task automatic clear_got();
      got_data.delete();
      got_keep.delete();
      got_cyc.delete();
   endtask

   task automatic wait_words(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (got_data.size() >= n) break;
         @(posedge rclk);
      end
      #1;
      ok = (got_data.size() >= n);
   endtask

   task automatic wait_pops(input int target, input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (pops >= target) break;
         @(posedge rclk);
      end
      #1;
      ok = (pops >= target);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge rclk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
      tests_run++;
      if (bus.out_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got %h expected 00000000", bus.out_data); end
      tests_run++;
      if (bus.out_keep !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_keep: got %h expected 0", bus.out_keep); end
      tests_run++;
      if (bus.rinc !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rinc: got %b expected 0", bus.rinc); end
      @(negedge rclk);
      rrst_n = 1'b1;
      repeat (2) @(posedge rclk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_valid: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_single_word();
      bit ok;
      int p0;
      clear_got();
      bus.out_ready = 1'b1;
      p0 = pops;
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
      wait_words(1, 40, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL single_timeout: got %0d words expected 1", got_data.size());
         return;
      end
      tests_run++;
      if (got_data[0] !== 32'h44332211) begin tests_failed++; $display("[TB] FAIL single_data: got %h expected 44332211", got_data[0]); end
      tests_run++;
      if (got_keep[0] !== 4'hF) begin tests_failed++; $display("[TB] FAIL single_keep: got %h expected f", got_keep[0]); end
      tests_run++;
      if (pops - p0 !== 4) begin tests_failed++; $display("[TB] FAIL single_pops: got %0d expected 4", pops - p0); end
      tests_run++;
      if (rise_cyc - last_pop_cyc !== 0) begin tests_failed++; $display("[TB] FAIL single_latency: got %0d expected 0", rise_cyc - last_pop_cyc); end
      repeat (3) @(posedge rclk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_valid_clear: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_multi_word();
      bit ok;
      logic [31:0] exp_w[3];
      exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09;
      clear_got();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 12; i++) write_byte(8'(i));
      wait_words(3, 100, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL multi_timeout: got %0d words expected 3", got_data.size());
         return;
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (got_data[i] !== exp_w[i] || got_keep[i] !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL multi_word%0d: got %h/%h expected %h/f", i, got_data[i], got_keep[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_timeout_flush();
      bit ok;
      int p0;
      clear_got();
      bus.out_ready = 1'b1;
      p0 = pops;
      write_byte(8'hA1); write_byte(8'hA2);
      wait_pops(p0 + 2, 20, ok);
      wait_words(1, 40, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL flush_timeout: got %0d words expected 1", got_data.size());
         return;
      end
      tests_run++;
      if (got_data[0] !== 32'h0000A2A1) begin tests_failed++; $display("[TB] FAIL flush_data: got %h expected 0000a2a1", got_data[0]); end
      tests_run++;
      if (got_keep[0] !== 4'b0011) begin tests_failed++; $display("[TB] FAIL flush_keep: got %b expected 0011", got_keep[0]); end
      tests_run++;
      if (rise_cyc - last_pop_cyc !== 16) begin tests_failed++; $display("[TB] FAIL flush_idle_cycles: got %0d expected 16", rise_cyc - last_pop_cyc); end
   endtask

   task automatic test_timeout_disabled();
      bit seen = 1'b0;
      @(posedge rclk); #1;
      bus0.rempty = 1'b0;
      bus0.rdata  = 8'hA1;
      @(posedge rclk); #1;
      bus0.rdata  = 8'hA2;
      @(posedge rclk); #1;
      bus0.rempty = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge rclk);
         if (bus0.out_valid) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL no_flush_valid: got %b expected 0", seen); end
      tests_run++;
      if (dut0.state !== ST_FILL) begin tests_failed++; $display("[TB] FAIL no_flush_state: got %0d expected %0d", dut0.state, ST_FILL); end
   endtask

   task automatic test_hold();
      bit ok;
      logic [31:0] exp_w[3];
      exp_w[0] = 32'h54535251; exp_w[1] = 32'h58575655; exp_w[2] = 32'h5C5B5A59;
      clear_got();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 12; i++) write_byte(8'h51 + 8'(i));
      repeat (4) @(posedge rclk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w[0]) begin
         tests_failed++;
         $display("[TB] FAIL hold_present: got %b/%h expected 1/%h", bus.out_valid, bus.out_data, exp_w[0]);
      end
      tests_run++;
      if (dut.state !== ST_HOLD) begin tests_failed++; $display("[TB] FAIL hold_state: got %0d expected %0d", dut.state, ST_HOLD); end
      tests_run++;
      if (bus.rinc !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_rinc: got %b expected 0", bus.rinc); end
      tests_run++;
      if (fq.size() !== 4) begin tests_failed++; $display("[TB] FAIL hold_fifo_level: got %0d expected 4", fq.size()); end
      repeat (5) @(posedge rclk);
      #1;
      tests_run++;
      if (bus.out_data !== exp_w[0] || bus.out_keep !== 4'hF) begin
         tests_failed++;
         $display("[TB] FAIL hold_stable: got %h/%h expected %h/f", bus.out_data, bus.out_keep, exp_w[0]);
      end
      bus.out_ready = 1'b1;
      wait_words(3, 60, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL hold_drain_timeout: got %0d words expected 3", got_data.size());
         return;
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (got_data[i] !== exp_w[i] || got_keep[i] !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL hold_word%0d: got %h/%h expected %h/f", i, got_data[i], got_keep[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] exp_w;
      clear_got();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 20; i++) write_byte(8'h61 + 8'(i));
      repeat (4) @(posedge rclk);
      #1;
      bus.out_ready = 1'b1;
      wait_words(5, 60, ok);
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("[TB] FAIL b2b_timeout: got %0d words expected 5", got_data.size());
         return;
      end
      for (int i = 0; i < 5; i++) begin
         exp_w = {8'h64 + 8'(4*i), 8'h63 + 8'(4*i), 8'h62 + 8'(4*i), 8'h61 + 8'(4*i)};
         tests_run++;
         if (got_data[i] !== exp_w) begin
            tests_failed++;
            $display("[TB] FAIL b2b_word%0d: got %h expected %h", i, got_data[i], exp_w);
         end
      end
      tests_run++;
      if (got_cyc[3] - got_cyc[2] !== 4 || got_cyc[4] - got_cyc[3] !== 4) begin
         tests_failed++;
         $display("[TB] FAIL b2b_spacing: got %0d,%0d expected 4,4", got_cyc[3] - got_cyc[2], got_cyc[4] - got_cyc[3]);
      end
   endtask

   task automatic test_random();
      logic [7:0] sb[$];
      logic [7:0] rx[$];
      bit wr_done = 1'b0;
      int mism = 0;
      int nbytes;
      clear_got();
      fork
         begin
            logic [7:0] b;
            for (int i = 0; i < 200; i++) begin
               b = 8'($urandom);
               sb.push_back(b);
               write_byte(b);
            end
            wr_done = 1'b1;
         end
         begin
            while (!wr_done) begin
               @(posedge rclk); #1;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      for (int i = 0; i < 1500; i++) begin
         nbytes = 0;
         foreach (got_keep[k]) nbytes += $countones(got_keep[k]);
         if (nbytes >= 200) break;
         @(posedge rclk); #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'b1;
      repeat (2) @(posedge rclk);
      #1;
      foreach (got_data[k]) begin
         for (int l = 0; l < 4; l++) begin
            if (got_keep[k][l]) rx.push_back(got_data[k][l*8 +: 8]);
         end
      end
      tests_run++;
      if (rx.size() !== 200) begin tests_failed++; $display("[TB] FAIL random_count: got %0d bytes expected 200", rx.size()); end
      for (int i = 0; i < 200 && i < rx.size(); i++) begin
         if (rx[i] !== sb[i]) mism++;
      end
      tests_run++;
      if (mism !== 0) begin tests_failed++; $display("[TB] FAIL random_data: got %0d byte errors expected 0", mism); end
      tests_run++;
      if (empty_pops !== 0) begin tests_failed++; $display("[TB] FAIL pop_when_empty: got %0d expected 0", empty_pops); end
   endtask

   task automatic test_reset_mid_word();
      bit ok;
      int p0;
      clear_got();
      bus.out_ready = 1'b1;
      p0 = pops;
      write_byte(8'hB1); write_byte(8'hB2);
      wait_pops(p0 + 2, 20, ok);
      @(posedge rclk);
      #10;
      rrst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_keep !== 4'h0 || bus.out_data !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got %b/%h/%h expected 0/0/00000000", bus.out_valid, bus.out_keep, bus.out_data);
      end
      repeat (2) @(posedge rclk);
      @(negedge rclk);
      rrst_n = 1'b1;
      clear_got();
      write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3); write_byte(8'hC4);
      wait_words(1, 40, ok);
      repeat (20) @(posedge rclk);
      #1;
      tests_run++;
      if (got_data.size() !== 1) begin
         tests_failed++;
         $display("[TB] FAIL reset_word_count: got %0d expected 1", got_data.size());
         return;
      end
      tests_run++;
      if (got_data[0] !== 32'hC4C3C2C1 || got_keep[0] !== 4'hF) begin
         tests_failed++;
         $display("[TB] FAIL reset_clean_word: got %h/%h expected c4c3c2c1/f", got_data[0], got_keep[0]);
      end
   endtask

   initial begin
      rrst_n         = 1'b0;
      bus.out_ready  = 1'b0;
      bus0.out_ready = 1'b1;
      bus0.rempty    = 1'b1;
      bus0.rdata     = 8'h00;
      test_reset();
      test_single_word();
      test_multi_word();
      test_timeout_flush();
      test_timeout_disabled();
      test_hold();
      test_back_to_back();
      test_random();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
